// File: rtl/ber_checker.sv
// ber_checker: BER checker with latency search.
// A PRBS reference is compared against the received bit stream. In SEARCH,
// each candidate latency L = 0..N_LAT-1 is tried for WIN symbol strobes, and
// the candidate with the fewest mismatches is kept. The FSM then enters LOCK,
// where it counts compared bits and errors at the chosen latency, with both
// counters saturating.
// Optional feature: define BER_CHECKER_RELOCK_EN to window the errors in LOCK.
// When a window contains more than WIN/2 errors, the FSM returns to SEARCH.
module ber_checker #(
  parameter int N_LAT  = 511,
  parameter int NB_LAT = 9,
  parameter int WIN    = 511,
  parameter int NB_WIN = 10,
  parameter int NB_CNT = 32
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_ref_bit,
  input  logic              i_rx_bit,
  output logic              o_locked,
  output logic [NB_LAT-1:0] o_latency,
  output logic [NB_CNT-1:0] o_error_count,
  output logic [NB_CNT-1:0] o_bit_count
);

  typedef enum logic [0:0] {
    ST_SEARCH = 1'b0,
    ST_LOCK   = 1'b1
  } state_e;

  localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(N_LAT - 1);
  localparam logic [NB_WIN-1:0] WIN_LAST = NB_WIN'(WIN - 1);
  localparam logic [NB_WIN-1:0] ERR_INIT = {NB_WIN{1'b1}};
  localparam logic [NB_CNT-1:0] CNT_MAX  = {NB_CNT{1'b1}};

  state_e            state_q, state_d;
  logic [NB_LAT-1:0] cand_q, cand_d;
  logic [NB_WIN-1:0] win_q, win_d;
  logic [NB_WIN-1:0] acc_q, acc_d;
  logic [NB_WIN-1:0] best_err_q, best_err_d;
  logic [NB_LAT-1:0] best_lat_q, best_lat_d;
  logic              locked_q, locked_d;
  logic [NB_LAT-1:0] latency_q, latency_d;
  logic [NB_CNT-1:0] err_cnt_q, err_cnt_d;
  logic [NB_CNT-1:0] bit_cnt_q, bit_cnt_d;
  // Holds the previous N_LAT-1 reference bits. Tap 0 is the current i_ref_bit.
  logic [N_LAT-2:0]  ref_dly_q, ref_dly_d;

  logic [N_LAT-1:0]  taps_s;
  logic              mis_search_s;
  logic              mis_lock_s;
  logic              mis_s;
  logic [NB_WIN-1:0] total_s;
  logic              win_end_s;
  logic              better_s;

  // Build the tap vector, and form the window total and mismatch flags for this strobe.
  always_comb begin
    taps_s       = {ref_dly_q, i_ref_bit};
    mis_search_s = i_rx_bit ^ taps_s[cand_q];
    mis_lock_s   = i_rx_bit ^ taps_s[latency_q];
    if (state_q == ST_LOCK) begin
      mis_s = mis_lock_s;
    end else begin
      mis_s = mis_search_s;
    end
    total_s   = acc_q + {{(NB_WIN-1){1'b0}}, mis_s};
    win_end_s = (win_q == WIN_LAST);
    better_s  = (total_s < best_err_q);
  end

  // Next-state logic: latency search, lock counting and optional loss of lock.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    win_d      = win_q;
    acc_d      = acc_q;
    best_err_d = best_err_q;
    best_lat_d = best_lat_q;
    locked_d   = locked_q;
    latency_d  = latency_q;
    err_cnt_d  = err_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    ref_dly_d  = ref_dly_q;
    if (i_enable) begin
      ref_dly_d = taps_s[N_LAT-2:0];
      case (state_q)
        ST_SEARCH: begin
          if (win_end_s) begin
            acc_d = {NB_WIN{1'b0}};
            win_d = {NB_WIN{1'b0}};
            if (better_s) begin
              best_err_d = total_s;
              best_lat_d = cand_q;
            end else begin
              best_err_d = best_err_q;
              best_lat_d = best_lat_q;
            end
            if (cand_q == LAT_LAST) begin
              state_d   = ST_LOCK;
              locked_d  = 1'b1;
              cand_d    = {NB_LAT{1'b0}};
              latency_d = better_s ? cand_q : best_lat_q;
              err_cnt_d = {NB_CNT{1'b0}};
              bit_cnt_d = {NB_CNT{1'b0}};
            end else begin
              cand_d = cand_q + NB_LAT'(1);
            end
          end else begin
            acc_d = total_s;
            win_d = win_q + NB_WIN'(1);
          end
        end
        ST_LOCK: begin
          if (bit_cnt_q != CNT_MAX) begin
            bit_cnt_d = bit_cnt_q + NB_CNT'(1);
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
          if (mis_lock_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + NB_CNT'(1);
          end else begin
            err_cnt_d = err_cnt_q;
          end
`ifdef BER_CHECKER_RELOCK_EN
          if (win_end_s) begin
            acc_d = {NB_WIN{1'b0}};
            win_d = {NB_WIN{1'b0}};
            if (total_s > NB_WIN'(WIN / 2)) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              cand_d     = {NB_LAT{1'b0}};
              best_err_d = ERR_INIT;
              best_lat_d = {NB_LAT{1'b0}};
            end else begin
              state_d = ST_LOCK;
            end
          end else begin
            acc_d = total_s;
            win_d = win_q + NB_WIN'(1);
          end
`else
          state_d = ST_LOCK;
`endif
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q    <= ST_SEARCH;
      cand_q     <= {NB_LAT{1'b0}};
      win_q      <= {NB_WIN{1'b0}};
      acc_q      <= {NB_WIN{1'b0}};
      best_err_q <= ERR_INIT;
      best_lat_q <= {NB_LAT{1'b0}};
      locked_q   <= 1'b0;
      latency_q  <= {NB_LAT{1'b0}};
      err_cnt_q  <= {NB_CNT{1'b0}};
      bit_cnt_q  <= {NB_CNT{1'b0}};
      ref_dly_q  <= {(N_LAT-1){1'b0}};
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      best_err_q <= best_err_d;
      best_lat_q <= best_lat_d;
      locked_q   <= locked_d;
      latency_q  <= latency_d;
      err_cnt_q  <= err_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      ref_dly_q  <= ref_dly_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_latency     = latency_q;
  assign o_error_count = err_cnt_q;
  assign o_bit_count   = bit_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: directed bench for ber_checker with N_LAT=16 and WIN=32.
// The reference is PRBS9, and rx is the reference delayed by 5 strobes.
// A second instance with NB_CNT=4 sees the same stimulus and exercises
// counter saturation. Expectations follow BER_CHECKER_RELOCK_EN when defined.
module tb_ber_checker;

  localparam int N_LAT  = 16;
  localparam int NB_LAT = 4;
  localparam int WIN    = 32;
  localparam int NB_WIN = 6;

  logic clock = 1'b0;
  logic i_reset, i_enable, i_ref_bit, i_rx_bit;

  logic              locked, s_locked;
  logic [NB_LAT-1:0] latency, s_latency;
  logic [31:0]       err_cnt, bit_cnt;
  logic [3:0]        s_err_cnt, s_bit_cnt;

  logic [8:0]  prbs;
  logic [15:0] hist;
  logic        invert;
  int          tests_run = 0;
  int          tests_failed = 0;

  ber_checker #(.N_LAT(N_LAT), .NB_LAT(NB_LAT), .WIN(WIN), .NB_WIN(NB_WIN), .NB_CNT(32)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
    .i_rx_bit(i_rx_bit), .o_locked(locked), .o_latency(latency),
    .o_error_count(err_cnt), .o_bit_count(bit_cnt));

  ber_checker #(.N_LAT(N_LAT), .NB_LAT(NB_LAT), .WIN(WIN), .NB_WIN(NB_WIN), .NB_CNT(4)) dut_small (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_ref_bit(i_ref_bit),
    .i_rx_bit(i_rx_bit), .o_locked(s_locked), .o_latency(s_latency),
    .o_error_count(s_err_cnt), .o_bit_count(s_bit_cnt));

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One symbol strobe: enable is high for 1 cycle, then low for 3 cycles.
  task automatic do_strobe(input logic flip);
    logic r;
    r    = prbs[8];
    prbs = {prbs[7:0], prbs[8] ^ prbs[4]};
    i_ref_bit = r;
    i_rx_bit  = hist[4] ^ flip ^ invert;
    hist      = {hist[14:0], r};
    i_enable  = 1'b1;
    @(posedge clock); #1;
    i_enable  = 1'b0;
    i_ref_bit = 1'($urandom);
    i_rx_bit  = 1'($urandom);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic run_strobes(input int n);
    for (int i = 0; i < n; i++) do_strobe(1'b0);
  endtask

  initial begin
    invert    = 1'b0;
    i_reset   = 1'b0;
    i_enable  = 1'b0;
    i_ref_bit = 1'b0;
    i_rx_bit  = 1'b0;
    // Reset held for 5 cycles with random inputs.
    for (int i = 0; i < 5; i++) begin
      i_enable  = 1'($urandom);
      i_ref_bit = 1'($urandom);
      i_rx_bit  = 1'($urandom);
      @(posedge clock); #1;
    end
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_latency", 32'(latency), 32'd0);
    check_eq("rst_err", err_cnt, 32'd0);
    check_eq("rst_bits", bit_cnt, 32'd0);
    check_eq("rst_small_err", 32'(s_err_cnt), 32'd0);

    i_enable = 1'b0;
    i_reset  = 1'b1;
    prbs     = 9'h1FF;
    hist     = 16'h0000;
    @(posedge clock); #1;

    // Search, with enable held low for 50 cycles part way through.
    for (int i = 1; i <= 511; i++) begin
      do_strobe(1'b0);
      if (i == 200) begin
        for (int k = 0; k < 50; k++) begin
          i_ref_bit = 1'($urandom);
          i_rx_bit  = 1'($urandom);
          @(posedge clock);
        end
        #1;
        check_eq("gap_locked", 32'(locked), 32'd0);
      end
    end
    check_eq("locked_511", 32'(locked), 32'd0);
    do_strobe(1'b0);
    check_eq("locked_512", 32'(locked), 32'd1);
    check_eq("latency", 32'(latency), 32'd5);
    check_eq("entry_bits", bit_cnt, 32'd0);
    check_eq("small_latency", 32'(s_latency), 32'd5);

    // Clean data while locked.
    run_strobes(1000);
    check_eq("clean_bits", bit_cnt, 32'd1000);
    check_eq("clean_err", err_cnt, 32'd0);
    check_eq("small_bits_sat", 32'(s_bit_cnt), 32'd15);
    check_eq("small_clean_err", 32'(s_err_cnt), 32'd0);

    // Flip every 100th strobe.
    for (int i = 1; i <= 1000; i++) do_strobe((i % 100) == 0);
    check_eq("flip_err", err_cnt, 32'd10);
    check_eq("flip_bits", bit_cnt, 32'd2000);
    check_eq("flip_locked", 32'(locked), 32'd1);
    check_eq("small_flip_err", 32'(s_err_cnt), 32'd10);

    // Inverted rx.
    invert = 1'b1;
`ifdef BER_CHECKER_RELOCK_EN
    run_strobes(15);
    check_eq("inv_locked_15", 32'(locked), 32'd1);
    check_eq("inv_err_15", err_cnt, 32'd25);
    run_strobes(1);
    check_eq("inv_unlocked_16", 32'(locked), 32'd0);
    check_eq("inv_latency_hold", 32'(latency), 32'd5);
    check_eq("inv_err_16", err_cnt, 32'd26);
    run_strobes(5);
    check_eq("inv_err_held", err_cnt, 32'd26);
    check_eq("inv_bits_held", bit_cnt, 32'd2016);
`else
    run_strobes(1);
    check_eq("inv_err_1", err_cnt, 32'd11);
    check_eq("inv_bits_1", bit_cnt, 32'd2001);
    run_strobes(39);
    check_eq("inv_err_40", err_cnt, 32'd50);
    check_eq("inv_bits_40", bit_cnt, 32'd2040);
    check_eq("inv_locked", 32'(locked), 32'd1);
`endif
    check_eq("small_err_sat", 32'(s_err_cnt), 32'd15);
    check_eq("small_bits_sat2", 32'(s_bit_cnt), 32'd15);

    // Reset in mid-lock discards progress, and the search restarts.
    invert  = 1'b0;
    i_reset = 1'b0;
    @(posedge clock); #1;
    check_eq("mid_rst_locked", 32'(locked), 32'd0);
    check_eq("mid_rst_latency", 32'(latency), 32'd0);
    check_eq("mid_rst_err", err_cnt, 32'd0);
    check_eq("mid_rst_bits", bit_cnt, 32'd0);
    i_reset = 1'b1;
    @(posedge clock); #1;
    run_strobes(511);
    check_eq("relock_511", 32'(locked), 32'd0);
    run_strobes(1);
    check_eq("relock_512", 32'(locked), 32'd1);
    check_eq("relock_latency", 32'(latency), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter N_LAT, default 511, is the number of candidate latencies searched (0..N_LAT-1).
REQ-002 Parameter NB_LAT, default 9, is the width of the latency output; 2^NB_LAT >= N_LAT.
REQ-003 Parameter WIN, default 511, is the error-accumulation window length in symbol strobes.
REQ-004 Parameter NB_WIN, default 10, is the window/accumulator width; 2^NB_WIN > WIN.
REQ-005 Parameter NB_CNT, default 32, is the width of the BER counters.
REQ-006 Port clock, input, 1: single system clock; all state updates on its rising edge.
REQ-007 Port i_reset, input, 1: synchronous, active-low reset.
REQ-008 Port i_enable, input, 1: symbol strobe from the symbol-rate counter; one decision per high cycle.
REQ-009 Port i_ref_bit, input, 1: transmitted PRBS bit, valid when i_enable=1.
REQ-010 Port i_rx_bit, input, 1: decoded bit (sign of the downsampled Tx-filter output), valid when i_enable=1.
REQ-011 Port o_locked, output, 1: high while in LOCK.
REQ-012 Port o_latency, output, NB_LAT: selected latency in strobes.
REQ-013 Port o_error_count, output, NB_CNT: mismatches counted in LOCK.
REQ-014 Port o_bit_count, output, NB_CNT: bits compared in LOCK.

Function
REQ-015 Delay line of N_LAT ref bits shall shift only on i_enable=1; candidate L compares i_rx_bit with the i_ref_bit presented L strobes earlier (L=0 = same strobe).
REQ-016 With i_enable=0, no register other than reset-driven ones shall change.
REQ-017 FSM states SHALL be SEARCH and LOCK; reset state SEARCH with candidate L=0, window count 0, accumulator 0, best_err=all-ones, best_lat=0.
REQ-018 In SEARCH, each strobe adds mismatch(L) to the accumulator; the WIN-th strobe's mismatch is included in that window's total.
REQ-019 At window end, if total < best_err (strict), best_err<=total, best_lat<=L; ties keep the lower L; then accumulator and window count clear, L increments.
REQ-020 At the window end of L=N_LAT-1, FSM enters LOCK on the same edge, o_latency<=best_lat (including this last window's result), o_locked<=1; total search = N_LAT*WIN strobes.
REQ-021 In LOCK, each strobe increments o_bit_count and, on mismatch at o_latency, o_error_count; both saturate at 2^NB_CNT-1 independently.
REQ-022 o_latency shall hold its value until reset or relock; o_bit_count/o_error_count clear on entry to LOCK.

Reset
REQ-023 i_reset=0 sampled on a rising edge shall force o_locked=0, o_latency=0, o_error_count=0, o_bit_count=0, delay line all zeros, FSM to REQ-017 values, overriding i_enable.
REQ-024 Reset mid-search or mid-lock shall discard all progress; search restarts at L=0 on the first strobe after release.

Configuration
REQ-025 Macro BER_CHECKER_RELOCK_EN defined: in LOCK, mismatches are also windowed over WIN strobes; if a window total > WIN/2 (integer), FSM returns to SEARCH on that edge with o_locked=0, REQ-017 values, counters and o_latency held.
REQ-026 Macro BER_CHECKER_RELOCK_EN undefined: LOCK is exited only by reset; no loss-of-lock logic synthesised.

Verification
REQ-027 Hold i_reset=0 5 cycles with random inputs -> o_locked=0, o_latency=0, both counters 0.
REQ-028 N_LAT=16, WIN=32, PRBS9 ref, rx=ref delayed 5 strobes, i_enable every 4th cycle -> o_locked rises after exactly 512 strobes, o_latency=5; after 1000 further strobes o_bit_count=1000, o_error_count=0.
REQ-029 Same setup, after lock flip rx every 100th strobe -> after 1000 strobes o_error_count=10.
REQ-030 Same setup, i_enable low 50 cycles mid-search -> lock still after exactly 512 strobes, o_latency=5.
REQ-031 Same setup, after lock invert rx -> with BER_CHECKER_RELOCK_EN o_locked falls at the first window end (<=32 strobes); without it o_locked stays 1 and o_error_count rises 1 per strobe.
REQ-032 NB_CNT=4, locked, rx inverted -> o_error_count and o_bit_count stop at 15.
